example_bus_arbiter: RTL and testbench



---
 rtl/example_bus_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_example_bus_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/example_bus_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// example_bus_arbiter
//
// Round-robin arbiter for the shared datapath output bus. One requester at a
// time owns the bus. Its data and valid are forwarded onto the bus
// combinationally. A tenure is capped at MAX_HOLD accepted beats, but only when
// somebody else is waiting. Every release is followed by one dead (GAP) cycle
// for bus turnaround.
//
// Parameters
//   NREQ      number of requesters (2..8)
//   PAR0      shared data bus width
//   MAX_HOLD  accepted beats per grant before forced release (>= 1)
//   CW        hold counter width (derived)
//   IW        owner index width (derived)
//
// Ports
//   example_clk    in   clock, rising edge
//   example_rst_n  in   asynchronous active-low reset
//   req            in   NREQ request lines, held for the whole tenure
//   req_data       in   packed data, requester i at [i*PAR0 +: PAR0]
//   gnt            out  registered one-hot grant (or zero)
//   bus_vld        out  |(gnt & req)
//   bus_data       out  current owner's data, zero when nothing is granted
//   bus_rdy        in   datapath accepts a beat on bus_vld & bus_rdy
//   bus_owner      out  index of current or most recent owner
//   preempt        out  one-cycle pulse when a tenure is cut by MAX_HOLD
// -----------------------------------------------------------------------------
module example_bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int PAR0     = 16,
    parameter int MAX_HOLD = 8,
    parameter int CW       = $clog2(MAX_HOLD + 1),
    parameter int IW       = $clog2(NREQ)
) (
    input  logic                 example_clk,
    input  logic                 example_rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*PAR0-1:0] req_data,
    output logic [NREQ-1:0]      gnt,
    output logic                 bus_vld,
    output logic [PAR0-1:0]      bus_data,
    input  logic                 bus_rdy,
    output logic [IW-1:0]        bus_owner,
    output logic                 preempt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [NREQ-1:0] GNT_NONE  = {NREQ{1'b0}};
    localparam logic [NREQ-1:0] GNT_ONE   = {{(NREQ-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   HOLD_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   HOLD_ONE  = CW'(1);
    localparam logic [CW-1:0]   HOLD_LAST = CW'(MAX_HOLD - 1);
    localparam logic [IW-1:0]   IDX_ZERO  = {IW{1'b0}};
    localparam logic [IW-1:0]   IDX_ONE   = IW'(1);
    localparam logic [IW-1:0]   IDX_LAST  = IW'(NREQ - 1);

    // First set request at or above ptr, wrapping modulo NREQ. The request
    // vector is doubled and shifted so bit 0 lines up with ptr, which keeps
    // the search to a constant-index scan.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IW-1:0]   p);
        logic [2*NREQ-1:0] rot;
        logic [IW-1:0]     win;
        logic              found;
        rot   = {r, r} >> p;
        win   = p;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rot[k]) begin
                win   = IW'((int'(p) + k) % NREQ);
                found = 1'b1;
            end else begin
                win   = win;
                found = found;
            end
        end
        return win;
    endfunction

    state_t            state_r,    state_s;
    logic [NREQ-1:0]   gnt_r,      gnt_s;
    logic [IW-1:0]     owner_r,    owner_s;
    logic [IW-1:0]     ptr_r,      ptr_s;
    logic [CW-1:0]     hold_cnt_r, hold_cnt_s;
    logic              preempt_r,  preempt_s;

    logic [IW-1:0]     pick_s;
    logic [IW-1:0]     next_ptr_s;
    logic              bus_vld_s;
    logic              others_s;
    logic [PAR0-1:0]   bus_data_s;

    assign pick_s     = rr_pick(req, ptr_r);
    assign next_ptr_s = (owner_r == IDX_LAST) ? IDX_ZERO : (owner_r + IDX_ONE);
    // The owner's request is the only one that can reach the bus.
    assign bus_vld_s  = |(gnt_r & req);
    assign others_s   = |(req & ~gnt_r);

    // Data mux: owner's slice, forced to zero whenever no grant is held.
    always_comb begin
        bus_data_s = {PAR0{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            bus_data_s = bus_data_s |
                ({PAR0{(owner_r == IW'(i)) && (|gnt_r)}} & req_data[i*PAR0 +: PAR0]);
        end
    end

    // Next-state, grant, pointer and hold-counter decisions.
    always_comb begin
        state_s    = state_r;
        gnt_s      = gnt_r;
        owner_s    = owner_r;
        ptr_s      = ptr_r;
        hold_cnt_s = hold_cnt_r;
        preempt_s  = 1'b0;
        case (state_r)
            // IDLE and GAP arbitrate identically; only GAP was forced dead.
            ST_IDLE, ST_GAP: begin
                if (|req) begin
                    state_s    = ST_BUSY;
                    gnt_s      = GNT_ONE << pick_s;
                    owner_s    = pick_s;
                    hold_cnt_s = HOLD_ZERO;
                end else begin
                    state_s    = ST_IDLE;
                    gnt_s      = GNT_NONE;
                end
            end
            ST_BUSY: begin
                // A dropped owner request wins over a same-cycle preemption;
                // with req low there is no valid beat to count anyway.
                if (!bus_vld_s) begin
                    state_s    = ST_GAP;
                    gnt_s      = GNT_NONE;
                    ptr_s      = next_ptr_s;
                    hold_cnt_s = HOLD_ZERO;
                end else if (bus_rdy) begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        if (others_s) begin
                            state_s    = ST_GAP;
                            gnt_s      = GNT_NONE;
                            ptr_s      = next_ptr_s;
                            preempt_s  = 1'b1;
                            hold_cnt_s = HOLD_ZERO;
                        end else begin
                            // Nobody waiting: start a fresh quota, keep bus.
                            hold_cnt_s = HOLD_ZERO;
                        end
                    end else begin
                        hold_cnt_s = hold_cnt_r + HOLD_ONE;
                    end
                end else begin
                    hold_cnt_s = hold_cnt_r;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                gnt_s      = GNT_NONE;
                hold_cnt_s = HOLD_ZERO;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge example_clk or negedge example_rst_n) begin
        if (!example_rst_n) begin
            state_r    <= ST_IDLE;
            gnt_r      <= GNT_NONE;
            owner_r    <= IDX_ZERO;
            ptr_r      <= IDX_ZERO;
            hold_cnt_r <= HOLD_ZERO;
            preempt_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            gnt_r      <= gnt_s;
            owner_r    <= owner_s;
            ptr_r      <= ptr_s;
            hold_cnt_r <= hold_cnt_s;
            preempt_r  <= preempt_s;
        end
    end

    assign gnt       = gnt_r;
    assign bus_owner = owner_r;
    assign preempt   = preempt_r;
    assign bus_vld   = bus_vld_s;
    assign bus_data  = bus_data_s;

endmodule

// File: tb/tb_example_bus_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for example_bus_arbiter: a directed vector table, a few
// hand-written multi-cycle sequences and a randomized run, all shadowed by a
// behavioural reference model that tracks owner/pointer/beat count as plain
// integers.
module tb_example_bus_arbiter;

    localparam int NREQ     = 4;
    localparam int PAR0     = 16;
    localparam int MAX_HOLD = 8;
    localparam int IW       = $clog2(NREQ);
    localparam logic [NREQ*PAR0-1:0] FIXED_DATA = 64'h4444_3333_2222_1111;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ*PAR0-1:0] req_data;
    logic [NREQ-1:0]      gnt;
    logic                 bus_vld;
    logic [PAR0-1:0]      bus_data;
    logic                 bus_rdy;
    logic [IW-1:0]        bus_owner;
    logic                 preempt;

    example_bus_arbiter #(
        .NREQ(NREQ), .PAR0(PAR0), .MAX_HOLD(MAX_HOLD)
    ) dut (
        .example_clk   (clk),
        .example_rst_n (rst_n),
        .req           (req),
        .req_data      (req_data),
        .gnt           (gnt),
        .bus_vld       (bus_vld),
        .bus_data      (bus_data),
        .bus_rdy       (bus_rdy),
        .bus_owner     (bus_owner),
        .preempt       (preempt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors;
    int miscompares;
    bit rand_data;

    // Reference model state: owner index (-1 = no grant), last owner,
    // round-robin pointer, beats accepted in this tenure, preempt pulse.
    int m_owner;
    int m_last;
    int m_ptr;
    int m_beats;
    bit m_pre;

    typedef struct packed {
        logic [NREQ-1:0] req;
        logic            rdy;
        logic [NREQ-1:0] gnt;
        logic            vld;
        logic [IW-1:0]   owner;
        logic            pre;
        logic [PAR0-1:0] data;
    } vec_t;

    vec_t tbl [14];

    int              owners[$];
    int              lens[$];
    int              pres;
    int              cur_len;
    int              g_cnt;
    logic [NREQ-1:0] prev_g;
    logic [NREQ-1:0] cur_req;
    int              exp_owner_seq[5];

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 0;
        m_ptr   = 0;
        m_beats = 0;
        m_pre   = 1'b0;
    endtask

    // Apply one clock edge worth of arbitration rules to the model.
    task automatic model_edge();
        logic [NREQ-1:0] om;
        logic [NREQ-1:0] sh;
        int              win;
        bit              pre_n;
        pre_n = 1'b0;
        if (m_owner < 0) begin
            win = -1;
            for (int k = 0; k < NREQ; k++) begin
                sh = req >> ((m_ptr + k) % NREQ);
                if (win < 0 && sh[0]) win = (m_ptr + k) % NREQ;
            end
            if (win >= 0) begin
                m_owner = win;
                m_last  = win;
                m_beats = 0;
            end
        end else begin
            om = NREQ'(1) << m_owner;
            if (!(|(req & om))) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
            end else if (bus_rdy) begin
                m_beats++;
                if (m_beats == MAX_HOLD) begin
                    m_beats = 0;
                    if (|(req & ~om)) begin
                        pre_n   = 1'b1;
                        m_ptr   = (m_owner + 1) % NREQ;
                        m_owner = -1;
                    end
                end
            end
        end
        m_pre = pre_n;
    endtask

    task automatic check_model();
        logic [NREQ-1:0] eg;
        logic [PAR0-1:0] ed;
        logic            ev;
        eg = '0;
        ed = '0;
        if (m_owner >= 0) begin
            eg = NREQ'(1) << m_owner;
            ed = PAR0'(req_data >> (m_owner * PAR0));
        end
        ev = |(req & eg);
        cmp("gnt",       64'(gnt),       64'(eg));
        cmp("bus_vld",   64'(bus_vld),   64'(ev));
        cmp("bus_data",  64'(bus_data),  64'(ed));
        cmp("bus_owner", 64'(bus_owner), 64'(m_last));
        cmp("preempt",   64'(preempt),   64'(m_pre));
        cmp("gnt_onehot0", 64'($onehot0(gnt)), 64'(1'b1));
    endtask

    task automatic settle_and_step();
        #1;
        check_model();
        model_edge();
    endtask

    task automatic drive(input logic [NREQ-1:0] r, input logic rdy);
        @(negedge clk);
        req     = r;
        bus_rdy = rdy;
        if (rand_data) req_data = {$urandom(), $urandom()};
        else           req_data = FIXED_DATA;
        settle_and_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        req     = '0;
        bus_rdy = 1'b0;
        #1;
        model_reset();
        check_model();
        @(negedge clk);
        rst_n = 1'b1;
        settle_and_step();
    endtask

    function automatic int oh_index(input logic [NREQ-1:0] v);
        int idx;
        idx = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) idx = i;
        return idx;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "time limit");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        rand_data   = 1'b0;
        rst_n       = 1'b0;
        req         = '0;
        req_data    = '0;
        bus_rdy     = 1'b0;
        model_reset();

        //            req      rdy   gnt      vld   own   pre   data
        tbl[0]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 16'h0000};
        tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 16'h0000};
        tbl[2]  = '{4'b0100, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 16'h0000};
        tbl[3]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b0, 16'h3333};
        tbl[4]  = '{4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0, 16'h3333};
        tbl[5]  = '{4'b0000, 1'b1, 4'b0100, 1'b0, 2'd2, 1'b0, 16'h3333};
        tbl[6]  = '{4'b1001, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0, 16'h0000};
        tbl[7]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b0, 16'h4444};
        tbl[8]  = '{4'b0001, 1'b1, 4'b1000, 1'b0, 2'd3, 1'b0, 16'h4444};
        tbl[9]  = '{4'b0001, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0, 16'h0000};
        tbl[10] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b0, 16'h1111};
        tbl[11] = '{4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0, 16'h1111};
        tbl[12] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 16'h0000};
        tbl[13] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 16'h0000};

        exp_owner_seq = '{0, 1, 2, 3, 0};

        // Reset values before any clock edge.
        #1;
        cmp("rst_gnt",     64'(gnt),      64'(4'b0000));
        cmp("rst_bus_vld", 64'(bus_vld),  64'(1'b0));
        cmp("rst_data",    64'(bus_data), 64'(16'h0000));
        cmp("rst_owner",   64'(bus_owner), 64'(2'd0));
        cmp("rst_preempt", 64'(preempt),  64'(1'b0));

        // Directed table: idle, grant latency, handover gaps, ptr wrap.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].req, tbl[i].rdy);
            cmp($sformatf("tbl%0d_gnt", i),   64'(gnt),       64'(tbl[i].gnt));
            cmp($sformatf("tbl%0d_vld", i),   64'(bus_vld),   64'(tbl[i].vld));
            cmp($sformatf("tbl%0d_owner", i), 64'(bus_owner), 64'(tbl[i].owner));
            cmp($sformatf("tbl%0d_pre", i),   64'(preempt),   64'(tbl[i].pre));
            cmp($sformatf("tbl%0d_data", i),  64'(bus_data),  64'(tbl[i].data));
        end

        rand_data = 1'b1;

        // Single requester never released, never preempted.
        do_reset();
        drive(4'b0100, 1'b1);
        g_cnt = 0;
        pres  = 0;
        for (int c = 0; c < 20; c++) begin
            drive(4'b0100, 1'b1);
            if (gnt == 4'b0100) g_cnt++;
            if (preempt) pres++;
            cmp("single_data", 64'(bus_data), 64'(req_data[47:32]));
        end
        cmp("single_grant_cycles", 64'(g_cnt), 64'(20));
        cmp("single_preempts",     64'(pres),  64'(0));

        // Round-robin fairness with all four requesting.
        do_reset();
        owners.delete();
        lens.delete();
        prev_g  = '0;
        pres    = 0;
        cur_len = 0;
        for (int c = 0; c < 45; c++) begin
            drive(4'b1111, 1'b1);
            if (gnt != 4'b0000 && prev_g == 4'b0000) begin
                owners.push_back(oh_index(gnt));
                cur_len = 0;
            end
            if (bus_vld) cur_len++;
            if (gnt == 4'b0000 && prev_g != 4'b0000) lens.push_back(cur_len);
            if (preempt) pres++;
            prev_g = gnt;
        end
        cmp("fair_grants", 64'(owners.size()), 64'(5));
        for (int i = 0; i < 5 && i < owners.size(); i++)
            cmp($sformatf("fair_owner%0d", i), 64'(owners[i]), 64'(exp_owner_seq[i]));
        cmp("fair_tenures", 64'(lens.size()), 64'(4));
        for (int i = 0; i < lens.size(); i++)
            cmp($sformatf("fair_len%0d", i), 64'(lens[i]), 64'(MAX_HOLD));
        cmp("fair_preempts", 64'(pres), 64'(4));

        // Back-pressure: only accepted beats count toward the quota.
        do_reset();
        drive(4'b0010, 1'b1);
        g_cnt = 0;
        pres  = 0;
        for (int k = 0; k < 18; k++) begin
            drive(4'b1010, ((k % 2) == 1));
            if (gnt == 4'b0010) g_cnt++;
            if (preempt) pres++;
        end
        cmp("bp_grant_cycles", 64'(g_cnt), 64'(16));
        cmp("bp_preempts",     64'(pres),  64'(1));
        cmp("bp_next_gnt",     64'(gnt),   64'(4'b1000));

        // Owner drops req on the cycle of its would-be final beat.
        do_reset();
        drive(4'b0001, 1'b1);
        for (int k = 0; k < 7; k++) drive(4'b0101, 1'b1);
        drive(4'b0100, 1'b1);
        cmp("coll_drop_gnt", 64'(gnt),     64'(4'b0001));
        cmp("coll_drop_vld", 64'(bus_vld), 64'(1'b0));
        drive(4'b0100, 1'b1);
        cmp("coll_gap_gnt",  64'(gnt),     64'(4'b0000));
        cmp("coll_gap_pre",  64'(preempt), 64'(1'b0));
        drive(4'b0100, 1'b1);
        cmp("coll_new_gnt",  64'(gnt),     64'(4'b0100));
        cmp("coll_new_pre",  64'(preempt), 64'(1'b0));

        // Asynchronous reset mid-tenure with ptr previously moved to 1.
        do_reset();
        drive(4'b0001, 1'b1);
        drive(4'b0000, 1'b1);
        drive(4'b0000, 1'b1);
        drive(4'b0010, 1'b1);
        drive(4'b0010, 1'b1);
        cmp("mid_gnt_before", 64'(gnt), 64'(4'b0010));
        #2;
        rst_n = 1'b0;
        req   = 4'b0011;
        #1;
        cmp("mid_rst_gnt",   64'(gnt),       64'(4'b0000));
        cmp("mid_rst_vld",   64'(bus_vld),   64'(1'b0));
        cmp("mid_rst_data",  64'(bus_data),  64'(16'h0000));
        cmp("mid_rst_owner", 64'(bus_owner), 64'(2'd0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        settle_and_step();
        drive(4'b0011, 1'b1);
        cmp("mid_rst_winner", 64'(gnt), 64'(4'b0001));

        // Randomized run with sticky requests against the model.
        do_reset();
        cur_req = '0;
        for (int c = 0; c < 500; c++) begin
            for (int b = 0; b < NREQ; b++)
                if ($urandom_range(0, 7) == 0) cur_req[b] = ~cur_req[b];
            drive(cur_req, ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
